target_tracker: RTL
===================

TARGET_TRACKER -- requirements
Module: target_tracker

Interface
REQ-001 SHALL have parameter MIN_PIX, default 64: minimum blob pixel count for a valid detection.
REQ-002 SHALL have parameter ACQ_FRAMES, default 3: consecutive valid frames needed to lock.
REQ-003 SHALL have parameter LOST_FRAMES, default 8: consecutive missed frames before dropping lock.
REQ-004 SHALL have parameter CENTER_X, default 256: camera-frame X reference.
REQ-005 SHALL have parameter CENTER_Y, default 240: camera-frame Y reference.
REQ-006 SHALL have parameter DEADBAND, default 8: error magnitude producing no command.
REQ-007 VGA_CLK  in  1  pixel clock (25 MHz); sole clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 bary_valid  in  1  one-cycle pulse, once per frame, new centroid from position stage.
REQ-010 bary_x  in  9  centroid X, camera coordinates 0..511.
REQ-011 bary_y  in  9  centroid Y, camera coordinates 0..511.
REQ-012 bary_cnt  in  18  pixels contributing to centroid.
REQ-013 trk_x, trk_y  out  9 each  filtered target position.
REQ-014 err_x, err_y  out  10 each  signed two's-complement error: trk minus CENTER.
REQ-015 cmd_left, cmd_right, cmd_up, cmd_down  out  1 each  steering commands.
REQ-016 locked  out  1  high while state is TRACK.
REQ-017 state  out  2  LOST=0, ACQUIRE=1, TRACK=2.
REQ-018 cmd_valid  out  1  one-cycle pulse when outputs have been updated.

Function
REQ-019 SHALL classify a bary_valid pulse as a hit iff bary_cnt >= MIN_PIX and bary_y <= 479; otherwise as a miss.
REQ-020 SHALL ignore bary_x/bary_y/bary_cnt when bary_valid=0; all outputs hold between pulses.
REQ-021 SHALL register all updates: outputs change, and cmd_valid pulses, exactly 1 cycle after bary_valid (hit or miss).
REQ-022 LOST + hit: trk loaded directly with (bary_x, bary_y); state -> ACQUIRE; acq_cnt=1.
REQ-023 LOST + miss: trk held; stays LOST.
REQ-024 ACQUIRE + hit: filter update (REQ-027); acq_cnt+1; -> TRACK when acq_cnt reaches ACQ_FRAMES.
REQ-025 ACQUIRE + miss: -> LOST; acq_cnt=0; trk held.
REQ-026 TRACK + hit: filter update; miss_cnt=0. TRACK + miss: trk held; miss_cnt+1, saturating; -> LOST when miss_cnt reaches LOST_FRAMES, miss_cnt cleared.
REQ-027 Filter, per axis: diff = bary - trk (10-bit signed); trk <= trk + (diff >>> 2), arithmetic shift (floor). Result always within 0..511; |diff| < 4 with diff >= 0 leaves trk unchanged (accepted residual).
REQ-028 err_x = trk_x - CENTER_X, err_y = trk_y - CENTER_Y, both sign-extended to 10 bits and recomputed from the new trk in the same cycle.
REQ-029 In TRACK: cmd_right iff err_x > DEADBAND; cmd_left iff err_x < -DEADBAND; cmd_down iff err_y > DEADBAND; cmd_up iff err_y < -DEADBAND. |err| == DEADBAND gives no command.
REQ-030 In LOST and ACQUIRE: all four cmd outputs 0.
REQ-031 cmd_left and cmd_right SHALL never be high together; likewise cmd_up and cmd_down.

Reset
REQ-032 reset SHALL act on a VGA_CLK rising edge only and take priority over a simultaneous bary_valid.
REQ-033 Reset values: state=LOST, trk=(CENTER_X, CENTER_Y), err=0, acq_cnt=0, miss_cnt=0, all cmd=0, locked=0, cmd_valid=0.
REQ-034 Reset asserted mid-ACQUIRE or mid-TRACK SHALL discard all history; the first hit after release behaves per REQ-022.

Verification
REQ-035 Reset -> state=0, trk=(256,240), err=(0,0), cmds=0, locked=0.
REQ-036 From LOST, hit x=300,y=200,cnt=500 -> next cycle trk=(300,200), state=1, cmd_valid=1, cmds=0.
REQ-037 Two more identical hits -> after the 3rd: state=2, locked=1, err_x=44 -> cmd_right=1; err_y=-40 -> cmd_up=1.
REQ-038 In TRACK with trk_x=300, hit bary_x=340 -> trk_x=310. Then bary_x=250 -> diff=-60 -> trk_x=295. Separately, with trk_x=264 (err_x=8) -> no horizontal command.
REQ-039 In TRACK: 7 misses (cnt=10) -> still TRACK, trk held; 8th miss -> LOST, cmds=0. A hit between misses resets miss_cnt. A pulse with bary_y=500, cnt=1000 counts as a miss.
REQ-040 reset=1 in the same cycle as a hit pulse -> reset values next cycle, cmd_valid=0.

Source files
------------

// File: rtl/target_tracker.sv
// Frame-rate target tracker: qualifies blob centroids and runs a LOST/ACQUIRE/TRACK lock machine.
// Smooths position with a 1/4-gain filter and issues deadband-limited steering commands.
module target_tracker #(
  parameter int MIN_PIX     = 64,
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 8,
  parameter int CENTER_X    = 256,
  parameter int CENTER_Y    = 240,
  parameter int DEADBAND    = 8
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic        bary_valid,
  input  logic [8:0]  bary_x,
  input  logic [8:0]  bary_y,
  input  logic [17:0] bary_cnt,
  output logic [8:0]  trk_x,
  output logic [8:0]  trk_y,
  output logic [9:0]  err_x,
  output logic [9:0]  err_y,
  output logic        cmd_left,
  output logic        cmd_right,
  output logic        cmd_up,
  output logic        cmd_down,
  output logic        locked,
  output logic [1:0]  state,
  output logic        cmd_valid
);

  localparam logic [1:0] ST_LOST    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_TRACK   = 2'd2;

  localparam logic [7:0]        ACQ_N   = 8'(ACQ_FRAMES);
  localparam logic [7:0]        LOST_N  = 8'(LOST_FRAMES);
  localparam logic [8:0]        CX      = 9'(CENTER_X);
  localparam logic [8:0]        CY      = 9'(CENTER_Y);
  localparam logic signed [9:0] DB_POS  = 10'(DEADBAND);
  localparam logic signed [9:0] DB_NEG  = -DB_POS;
  localparam logic [17:0]       MIN_CNT = 18'(MIN_PIX);

  logic [1:0] state_q, state_d;
  logic [8:0] trk_x_q, trk_x_d, trk_y_q, trk_y_d;
  logic [9:0] err_x_q, err_x_d, err_y_q, err_y_d;
  logic [7:0] acq_cnt_q, acq_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [3:0] cmd_q, cmd_d;  // {left, right, up, down}
  logic       cmd_valid_q, cmd_valid_d;

  logic              hit;
  logic signed [9:0] diff_x, diff_y;
  logic signed [9:0] step_x, step_y;
  logic [9:0]        filt_x, filt_y;
  logic [9:0]        pos_x, pos_y;

  assign hit = (bary_cnt >= MIN_CNT) && (bary_y <= 9'd479);

  // Position stays inside 0..511, so the 10-bit sum never wraps and bit 9 is always 0.
  assign diff_x = $signed({1'b0, bary_x}) - $signed({1'b0, trk_x_q});
  assign diff_y = $signed({1'b0, bary_y}) - $signed({1'b0, trk_y_q});
  assign step_x = diff_x >>> 2;
  assign step_y = diff_y >>> 2;
  assign filt_x = {1'b0, trk_x_q} + step_x;
  assign filt_y = {1'b0, trk_y_q} + step_y;

  always_comb begin
    // NOTE: every value driven here gets a hold default first, so no path can infer a latch.
    state_d     = state_q;
    acq_cnt_d   = acq_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    pos_x       = {1'b0, trk_x_q};
    pos_y       = {1'b0, trk_y_q};
    err_x_d     = err_x_q;
    err_y_d     = err_y_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;

    if (bary_valid) begin
      cmd_valid_d = 1'b1;
      case (state_q)
        ST_LOST: begin
          if (hit) begin
            pos_x     = {1'b0, bary_x};
            pos_y     = {1'b0, bary_y};
            state_d   = ST_ACQUIRE;
            acq_cnt_d = 8'd1;
          end
        end
        ST_ACQUIRE: begin
          if (hit) begin
            pos_x     = filt_x;
            pos_y     = filt_y;
            acq_cnt_d = acq_cnt_q + 8'd1;
            if (acq_cnt_d >= ACQ_N) state_d = ST_TRACK;
          end else begin
            state_d   = ST_LOST;
            acq_cnt_d = 8'd0;
          end
        end
        ST_TRACK: begin
          if (hit) begin
            pos_x      = filt_x;
            pos_y      = filt_y;
            miss_cnt_d = 8'd0;
          end else begin
            if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
            if (miss_cnt_d >= LOST_N) begin
              state_d    = ST_LOST;
              miss_cnt_d = 8'd0;
              acq_cnt_d  = 8'd0;
            end
          end
        end
        default: begin
          state_d    = ST_LOST;
          acq_cnt_d  = 8'd0;
          miss_cnt_d = 8'd0;
        end
      endcase

      err_x_d = pos_x - {1'b0, CX};
      err_y_d = pos_y - {1'b0, CY};

      // Commands follow the post-update state, so the lock cycle already steers.
      cmd_d = 4'b0000;
      if (state_d == ST_TRACK) begin
        cmd_d[3] = $signed(err_x_d) < DB_NEG;
        cmd_d[2] = $signed(err_x_d) > DB_POS;
        cmd_d[1] = $signed(err_y_d) < DB_NEG;
        cmd_d[0] = $signed(err_y_d) > DB_POS;
      end
    end

    trk_x_d = pos_x[8:0];
    trk_y_d = pos_y[8:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state_q     <= ST_LOST;
      trk_x_q     <= CX;
      trk_y_q     <= CY;
      err_x_q     <= 10'd0;
      err_y_q     <= 10'd0;
      acq_cnt_q   <= 8'd0;
      miss_cnt_q  <= 8'd0;
      cmd_q       <= 4'b0000;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trk_x_q     <= trk_x_d;
      trk_y_q     <= trk_y_d;
      err_x_q     <= err_x_d;
      err_y_q     <= err_y_d;
      acq_cnt_q   <= acq_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign trk_x     = trk_x_q;
  assign trk_y     = trk_y_q;
  assign err_x     = err_x_q;
  assign err_y     = err_y_q;
  assign cmd_left  = cmd_q[3];
  assign cmd_right = cmd_q[2];
  assign cmd_up    = cmd_q[1];
  assign cmd_down  = cmd_q[0];
  assign locked    = (state_q == ST_TRACK);
  assign state     = state_q;
  assign cmd_valid = cmd_valid_q;

endmodule
